// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: operand forwarding, load-use stalls, taken-branch flushes,
// an external drain-then-load PC sequence, and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset_n,
    input  logic             SYS_load,
    input  logic [4:0]       D_rs,
    input  logic [4:0]       D_rt,
    input  logic             D_uses_rt,
    input  logic [4:0]       EX_rs,
    input  logic [4:0]       EX_rt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_write_register,
    input  logic             EX_branch_taken,
    input  logic             MEM_RegWrite,
    input  logic [4:0]       MEM_write_register,
    input  logic             WB_RegWrite,
    input  logic [4:0]       WB_write_register,
    output logic             PC_en,
    output logic             PC_sel_branch,
    output logic             PC_load,
    output logic             D_en,
    output logic             D_flush,
    output logic             EX_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             CTRL_busy,
    output logic [CNT_W-1:0] CTRL_stall_count,
    output logic [CNT_W-1:0] CTRL_flush_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    // MEM result is newer than WB data, so it wins; r0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd,
        input logic [4:0] src
    );
        logic [1:0] sel;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
            sel = 2'b10;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       load_use_s;
    logic       pc_en_s, pc_sel_branch_s, pc_load_s;
    logic       d_en_s, d_flush_s, ex_bubble_s, busy_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    // Hazard detection and forwarding selects, independent of sequencer state.
    always_comb begin
        load_use_s = EX_MemRead && (EX_write_register != 5'd0) &&
                     ((EX_write_register == D_rs) ||
                      (D_uses_rt && (EX_write_register == D_rt)));
        fwd_a_s = fwd_sel(MEM_RegWrite, MEM_write_register, WB_RegWrite, WB_write_register, EX_rs);
        fwd_b_s = fwd_sel(MEM_RegWrite, MEM_write_register, WB_RegWrite, WB_write_register, EX_rt);
    end

    // Sequencer next state, pipeline controls and counter updates.
    always_comb begin
        state_d         = state_q;
        drain_cnt_d     = drain_cnt_q;
        stall_cnt_d     = stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        pc_en_s         = 1'b0;
        pc_sel_branch_s = 1'b0;
        pc_load_s       = 1'b0;
        d_en_s          = 1'b0;
        d_flush_s       = 1'b0;
        ex_bubble_s     = 1'b0;
        busy_s          = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (EX_branch_taken) begin
                    // Squashes any load-use victim in decode; a concurrent SYS_load waits a cycle.
                    pc_en_s         = 1'b1;
                    pc_sel_branch_s = 1'b1;
                    d_en_s          = 1'b1;
                    d_flush_s       = 1'b1;
                    ex_bubble_s     = 1'b1;
                    flush_cnt_d     = sat_inc(flush_cnt_q);
                end else if (SYS_load) begin
                    d_en_s      = 1'b1;
                    d_flush_s   = 1'b1;
                    ex_bubble_s = 1'b1;
                    drain_cnt_d = DRAIN_INIT;
                    state_d     = ST_DRAIN;
                end else if (load_use_s) begin
                    ex_bubble_s = 1'b1;
                    stall_cnt_d = sat_inc(stall_cnt_q);
                end else begin
                    pc_en_s = 1'b1;
                    d_en_s  = 1'b1;
                end
            end
            ST_DRAIN: begin
                d_en_s      = 1'b1;
                d_flush_s   = 1'b1;
                ex_bubble_s = 1'b1;
                busy_s      = 1'b1;
                if (drain_cnt_q == 4'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    drain_cnt_d = drain_cnt_q - 4'd1;
                end
            end
            ST_LOAD: begin
                pc_en_s     = 1'b1;
                pc_load_s   = 1'b1;
                d_en_s      = 1'b1;
                d_flush_s   = 1'b1;
                ex_bubble_s = 1'b1;
                busy_s      = 1'b1;
                state_d     = ST_RUN;
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = 4'd0;
            end
        endcase
    end

    // State shares the falling edge with the pipeline registers it controls.
    always_ff @(negedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 4'd0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Every output is forced low while reset is held, independent of the clock.
    always_comb begin
        PC_en            = SYS_reset_n & pc_en_s;
        PC_sel_branch    = SYS_reset_n & pc_sel_branch_s;
        PC_load          = SYS_reset_n & pc_load_s;
        D_en             = SYS_reset_n & d_en_s;
        D_flush          = SYS_reset_n & d_flush_s;
        EX_bubble        = SYS_reset_n & ex_bubble_s;
        CTRL_busy        = SYS_reset_n & busy_s;
        fwd_a            = {2{SYS_reset_n}} & fwd_a_s;
        fwd_b            = {2{SYS_reset_n}} & fwd_b_s;
        CTRL_stall_count = {CNT_W{SYS_reset_n}} & stall_cnt_q;
        CTRL_flush_count = {CNT_W{SYS_reset_n}} & flush_cnt_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic, checked
// against a cycle-level behavioural model of the pipeline control rules.
module tb_hazard_ctrl;

    localparam int DRAIN = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct {
        bit       rst_n, load, d_uses_rt, ex_memread, br, mem_we, wb_we;
        bit [4:0] d_rs, d_rt, ex_rs, ex_rt, ex_wr, mem_wr, wb_wr;
    } stim_t;

    typedef struct {
        int       cyc;
        bit       pc_en, sel, pcl, den, dfl, bub, busy;
        bit [1:0] fa, fb;
        int       sc, fc;
    } exp_t;

    logic SYS_clk = 1'b1;
    logic SYS_reset_n = 1'b0;
    logic SYS_load = 1'b0;
    logic [4:0] D_rs = 5'd0, D_rt = 5'd0, EX_rs = 5'd0, EX_rt = 5'd0;
    logic D_uses_rt = 1'b0, EX_MemRead = 1'b0, EX_branch_taken = 1'b0;
    logic [4:0] EX_write_register = 5'd0, MEM_write_register = 5'd0, WB_write_register = 5'd0;
    logic MEM_RegWrite = 1'b0, WB_RegWrite = 1'b0;
    logic PC_en, PC_sel_branch, PC_load, D_en, D_flush, EX_bubble, CTRL_busy;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] CTRL_stall_count, CTRL_flush_count;

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .SYS_clk(SYS_clk), .SYS_reset_n(SYS_reset_n), .SYS_load(SYS_load),
        .D_rs(D_rs), .D_rt(D_rt), .D_uses_rt(D_uses_rt),
        .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_MemRead(EX_MemRead),
        .EX_write_register(EX_write_register), .EX_branch_taken(EX_branch_taken),
        .MEM_RegWrite(MEM_RegWrite), .MEM_write_register(MEM_write_register),
        .WB_RegWrite(WB_RegWrite), .WB_write_register(WB_write_register),
        .PC_en(PC_en), .PC_sel_branch(PC_sel_branch), .PC_load(PC_load),
        .D_en(D_en), .D_flush(D_flush), .EX_bubble(EX_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .CTRL_busy(CTRL_busy),
        .CTRL_stall_count(CTRL_stall_count), .CTRL_flush_count(CTRL_flush_count)
    );

    always #5 SYS_clk = ~SYS_clk;

    exp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    int   m_busy_left = 0, m_stall = 0, m_flush = 0;
    bit   last_pcl = 1'b0;

    function automatic bit [1:0] ref_fwd(input stim_t s, input bit [4:0] src);
        if (s.mem_we && s.mem_wr != 0 && s.mem_wr == src) return 2'b10;
        if (s.wb_we && s.wb_wr != 0 && s.wb_wr == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s = '{default: 0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    // Drive one clock period of inputs and queue what the model says the DUT must show.
    task automatic apply(input stim_t s);
        exp_t e = '{default: 0};
        bit lu;
        @(negedge SYS_clk);
        #1;
        SYS_reset_n = s.rst_n; SYS_load = s.load;
        D_rs = s.d_rs; D_rt = s.d_rt; D_uses_rt = s.d_uses_rt;
        EX_rs = s.ex_rs; EX_rt = s.ex_rt; EX_MemRead = s.ex_memread;
        EX_write_register = s.ex_wr; EX_branch_taken = s.br;
        MEM_RegWrite = s.mem_we; MEM_write_register = s.mem_wr;
        WB_RegWrite = s.wb_we; WB_write_register = s.wb_wr;
        e.cyc = cyc;
        cyc++;
        if (!s.rst_n) begin
            m_busy_left = 0; m_stall = 0; m_flush = 0;
        end else begin
            e.fa = ref_fwd(s, s.ex_rs);
            e.fb = ref_fwd(s, s.ex_rt);
            e.sc = m_stall;
            e.fc = m_flush;
            lu = s.ex_memread && s.ex_wr != 0 &&
                 (s.ex_wr == s.d_rs || (s.d_uses_rt && s.ex_wr == s.d_rt));
            if (m_busy_left > 0) begin
                e.busy = 1; e.den = 1; e.dfl = 1; e.bub = 1;
                e.pc_en = (m_busy_left == 1);
                e.pcl   = (m_busy_left == 1);
                m_busy_left--;
            end else if (s.br) begin
                e.pc_en = 1; e.sel = 1; e.den = 1; e.dfl = 1; e.bub = 1;
                if (m_flush < CMAX) m_flush++;
            end else if (s.load) begin
                e.den = 1; e.dfl = 1; e.bub = 1;
                m_busy_left = DRAIN + 1;
            end else if (lu) begin
                e.bub = 1;
                if (m_stall < CMAX) m_stall++;
            end else begin
                e.pc_en = 1; e.den = 1;
            end
        end
        last_pcl = e.pcl;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int c, input int act, input int want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, c, act, want);
        end
    endtask

    // Monitor: compare the oldest queued expectation mid-period, away from the falling edge.
    always @(posedge SYS_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("PC_en", e.cyc, int'(PC_en), int'(e.pc_en));
            chk("PC_sel_branch", e.cyc, int'(PC_sel_branch), int'(e.sel));
            chk("PC_load", e.cyc, int'(PC_load), int'(e.pcl));
            chk("D_en", e.cyc, int'(D_en), int'(e.den));
            chk("D_flush", e.cyc, int'(D_flush), int'(e.dfl));
            chk("EX_bubble", e.cyc, int'(EX_bubble), int'(e.bub));
            chk("CTRL_busy", e.cyc, int'(CTRL_busy), int'(e.busy));
            chk("fwd_a", e.cyc, int'(fwd_a), int'(e.fa));
            chk("fwd_b", e.cyc, int'(fwd_b), int'(e.fb));
            chk("stall_count", e.cyc, int'(CTRL_stall_count), e.sc);
            chk("flush_count", e.cyc, int'(CTRL_flush_count), e.fc);
        end
    end

    initial begin
        stim_t s;
        bit    load_req = 1'b0;
        int    wait_cnt = 0;

        s = idle(); s.rst_n = 0;
        apply(s); apply(s);
        apply(idle());

        // Forwarding: MEM beats WB, then WB alone.
        s = idle(); s.mem_we = 1; s.mem_wr = 8; s.wb_we = 1; s.wb_wr = 8; s.ex_rs = 8; s.ex_rt = 9;
        apply(s);
        s.mem_we = 0;
        apply(s);
        // Register 0 is never forwarded.
        s = idle(); s.mem_we = 1; s.wb_we = 1; apply(s);

        // Load-use stall on rs, then rt match without D_uses_rt (no stall).
        s = idle(); s.ex_memread = 1; s.ex_wr = 5; s.d_rs = 5;
        apply(s);
        s.d_rs = 6; s.d_rt = 5; apply(s);
        s.d_uses_rt = 1; apply(s);
        s = idle(); s.ex_memread = 1; apply(s);

        // Branch overrides load-use.
        s = idle(); s.ex_memread = 1; s.ex_wr = 5; s.d_rs = 5; s.br = 1;
        apply(s);

        // Drain/load sequence with branches ignored while busy.
        s = idle(); s.load = 1; apply(s);
        s.br = 1;
        for (int i = 0; i < DRAIN + 1; i++) apply(s);
        apply(idle());

        // Reset in the middle of a drain.
        s = idle(); s.load = 1; apply(s);
        apply(s);
        s.rst_n = 0; apply(s);
        for (int i = 0; i < DRAIN + 3; i++) apply(idle());

        // Randomised traffic with a level-sensitive load requester.
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.d_rs = 5'($urandom_range(0, 3));
            s.d_rt = 5'($urandom_range(0, 3));
            s.ex_rs = 5'($urandom_range(0, 3));
            s.ex_rt = 5'($urandom_range(0, 3));
            s.ex_wr = 5'($urandom_range(0, 3));
            s.mem_wr = 5'($urandom_range(0, 3));
            s.wb_wr = 5'($urandom_range(0, 3));
            s.d_uses_rt = 1'($urandom_range(0, 1));
            s.ex_memread = 1'($urandom_range(0, 1));
            s.mem_we = 1'($urandom_range(0, 1));
            s.wb_we = 1'($urandom_range(0, 1));
            s.br = ($urandom_range(0, 11) == 0);
            if (last_pcl && $urandom_range(0, 3) != 0) load_req = 1'b0;
            else if (!load_req && $urandom_range(0, 39) == 0) load_req = 1'b1;
            s.load = load_req;
            if ($urandom_range(0, 149) == 0) begin
                s.rst_n = 0;
                load_req = 1'b0;
            end
            apply(s);
        end

        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge SYS_clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_queue got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
